// File: rtl/fta_bus_pkg.sv
// fta 128-bit command bus types shared by bus masters and slaves.
package fta_bus_pkg;

  typedef struct packed {
    logic [5:0] core;
    logic [2:0] channel;
    logic [3:0] tranid;
  } fta_tranid_t;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
    fta_tranid_t  tid;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic         ack;
    logic         rty;
    logic [127:0] dat;
    fta_tranid_t  tid;
  } fta_cmd_response128_t;

endpackage

// File: rtl/rf80386_pkg.sv
// Shared types and constants for the rf80386 instruction buffer.
package rf80386_pkg;

  typedef enum logic [1:0] {IBUF_IDLE, IBUF_REQ, IBUF_WAIT} e_ibuf_state;

  typedef struct packed {
    logic [27:0]  tag;
    logic         vld;
    logic [127:0] dat;
  } ibuf_line_t;

  localparam logic [7:0] IBUF_NOP = 8'h90;

  function automatic logic [127:0] nop_bundle();
    return {16{IBUF_NOP}};
  endfunction

endpackage

// File: rtl/rf80386_ibuf_lookup.sv
// Fully-associative tag compare for the current line (A) and the following line (B).
module rf80386_ibuf_lookup
  import rf80386_pkg::*;
#(
  parameter int NLINES = 4
) (
  input  ibuf_line_t         i_lines [NLINES],
  input  logic [27:0]        i_tag_a,
  input  logic [27:0]        i_tag_b,
  output logic               o_hit_a,
  output logic               o_hit_b,
  output logic [NLINES-1:0]  o_oh_a,
  output logic [NLINES-1:0]  o_oh_b,
  output logic [127:0]       o_dat_a,
  output logic [119:0]       o_dat_b
);

  genvar gi;
  generate
    for (gi = 0; gi < NLINES; gi++) begin : g_cmp
      assign o_oh_a[gi] = i_lines[gi].vld && (i_lines[gi].tag == i_tag_a);
      assign o_oh_b[gi] = i_lines[gi].vld && (i_lines[gi].tag == i_tag_b);
    end
  endgenerate

  assign o_hit_a = |o_oh_a;
  assign o_hit_b = |o_oh_b;

  // The last byte of B can never fall inside a 16-byte window, so it is not returned.
  always_comb begin
    o_dat_a = '0;
    o_dat_b = '0;
    for (int i = 0; i < NLINES; i++) begin
      if (o_oh_a[i]) o_dat_a = o_dat_a | i_lines[i].dat;
      if (o_oh_b[i]) o_dat_b = o_dat_b | i_lines[i].dat[119:0];
    end
  end

endmodule

// File: rtl/rf80386_ibuf.sv
// rf80386 instruction line buffer: 16-byte bundle at csip from a small line store filled over fta.
// Optional next-line prefetch is enabled by defining RF80386_IBUF_PREFETCH_EN.
module rf80386_ibuf
  import fta_bus_pkg::*;
  import rf80386_pkg::*;
#(
  parameter logic [5:0] CORENO = 6'd1,
  parameter logic [2:0] CID    = 3'd1,
  parameter int         NLINES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          csip,
  input  logic                 inv_i,
  output logic [127:0]         ibundle,
  output logic                 ihit,
  output fta_cmd_request128_t  ftam_req,
  input  fta_cmd_response128_t ftam_resp
);

  localparam int PW = $clog2(NLINES);

  ibuf_line_t   r_lines [NLINES];
  e_ibuf_state  r_state;
  e_ibuf_state  w_state_next;
  logic         r_drop;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_victim;
  logic [3:0]   r_tranid;
  logic [27:0]  r_tag;

  logic [27:0]  w_tag_a, w_tag_b, w_fetch_tag;
  logic         w_need_b, w_hit_a, w_hit_b, w_hit_c, w_fetch, w_resp_match;
  logic [NLINES-1:0] w_oh_a, w_oh_b, w_oh_c, w_excl;
  logic [127:0] w_dat_a;
  logic [119:0] w_dat_b;
  logic [PW-1:0] w_victim, w_vic_idx;
  logic         w_vic_found;

  assign w_tag_a  = csip[31:4];
  assign w_tag_b  = w_tag_a + 28'd1;
  assign w_need_b = |csip[3:0];

  rf80386_ibuf_lookup #(.NLINES(NLINES)) u_lookup (
    .i_lines (r_lines),
    .i_tag_a (w_tag_a),
    .i_tag_b (w_tag_b),
    .o_hit_a (w_hit_a),
    .o_hit_b (w_hit_b),
    .o_oh_a  (w_oh_a),
    .o_oh_b  (w_oh_b),
    .o_dat_a (w_dat_a),
    .o_dat_b (w_dat_b)
  );

`ifdef RF80386_IBUF_PREFETCH_EN
  logic [27:0] w_tag_c;
  assign w_tag_c = w_tag_a + (w_need_b ? 28'd2 : 28'd1);
  genvar gi;
  generate
    for (gi = 0; gi < NLINES; gi++) begin : g_cmp_c
      assign w_oh_c[gi] = r_lines[gi].vld && (r_lines[gi].tag == w_tag_c);
    end
  endgenerate
  assign w_hit_c = |w_oh_c;
`else
  assign w_oh_c  = '0;
  assign w_hit_c = 1'b1;
`endif

  assign ihit    = ~rst_i & w_hit_a & (w_hit_b | ~w_need_b);
  assign ibundle = ihit ? 128'({w_dat_b, w_dat_a} >> {csip[3:0], 3'd0}) : nop_bundle();

  // Lines needed right now (and the prefetch target) are never chosen as victim.
  assign w_excl = w_oh_a | (w_need_b ? w_oh_b : '0) | w_oh_c;

  always_comb begin
    w_victim    = r_ptr;
    w_vic_found = 1'b0;
    w_vic_idx   = '0;
    for (int k = 0; k < NLINES; k++) begin
      w_vic_idx = r_ptr + PW'(k);
      if (!w_vic_found && !w_excl[w_vic_idx]) begin
        w_victim    = w_vic_idx;
        w_vic_found = 1'b1;
      end
    end
  end

  assign w_resp_match = (ftam_resp.tid == {CORENO, CID, r_tranid});

  always_comb begin
    w_state_next = r_state;
    w_fetch      = 1'b0;
    w_fetch_tag  = w_tag_a;
    ftam_req     = '0;
    ftam_req.tid = {CORENO, CID, r_tranid};
    case (r_state)
      IBUF_IDLE: begin
        if (!w_hit_a) begin
          w_fetch = 1'b1;
        end else if (w_need_b && !w_hit_b) begin
          w_fetch     = 1'b1;
          w_fetch_tag = w_tag_b;
        end else if (!w_hit_c) begin
          w_fetch     = 1'b1;
          w_fetch_tag = w_tag_a + (w_need_b ? 28'd2 : 28'd1);
        end
        if (w_fetch) w_state_next = IBUF_REQ;
      end
      IBUF_REQ: begin
        ftam_req.cyc = 1'b1;
        ftam_req.stb = 1'b1;
        ftam_req.sel = 16'hFFFF;
        ftam_req.adr = {r_tag, 4'h0};
        w_state_next = IBUF_WAIT;
      end
      IBUF_WAIT: begin
        ftam_req.cyc = 1'b1;
        ftam_req.sel = 16'hFFFF;
        ftam_req.adr = {r_tag, 4'h0};
        if (ftam_resp.ack && w_resp_match)      w_state_next = IBUF_IDLE;
        else if (ftam_resp.rty && w_resp_match) w_state_next = IBUF_REQ;
      end
      default: w_state_next = IBUF_IDLE;
    endcase
    // Drop the bus cycle from the very first reset cycle, not one clock later.
    if (rst_i) begin
      ftam_req     = '0;
      ftam_req.tid = {CORENO, CID, 4'd0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IBUF_IDLE;
      r_drop   <= 1'b0;
      r_ptr    <= '0;
      r_victim <= '0;
      r_tranid <= 4'd1;
      r_tag    <= '0;
      for (int i = 0; i < NLINES; i++) r_lines[i] <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IBUF_IDLE && w_fetch) begin
        r_tag    <= w_fetch_tag;
        r_victim <= w_victim;
      end
      if (inv_i) begin
        for (int i = 0; i < NLINES; i++) r_lines[i].vld <= 1'b0;
        if (r_state != IBUF_IDLE) r_drop <= 1'b1;
      end
      if (r_state == IBUF_WAIT && ftam_resp.ack && w_resp_match) begin
        r_tranid <= (r_tranid == 4'd15) ? 4'd1 : r_tranid + 4'd1;
        r_drop   <= 1'b0;
        if (!r_drop && !inv_i) begin
          r_lines[r_victim] <= '{tag: r_tag, vld: 1'b1, dat: ftam_resp.dat};
          r_ptr             <= r_victim + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rf80386_ibuf.sv
// Directed self-checking bench for rf80386_ibuf; memory line at adr holds bytes adr[7:0]+k.
module tb_rf80386_ibuf;
  import fta_bus_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [31:0]          csip;
  logic                 inv;
  logic [127:0]         ibundle;
  logic                 ihit;
  fta_cmd_request128_t  req;
  fta_cmd_response128_t resp;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_adr;
  localparam logic [127:0] NOPS = {16{8'h90}};

  always #5 clk = ~clk;

  rf80386_ibuf dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .csip      (csip),
    .inv_i     (inv),
    .ibundle   (ibundle),
    .ihit      (ihit),
    .ftam_req  (req),
    .ftam_resp (resp)
  );

  function automatic logic [127:0] line_data(input logic [31:0] adr);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = adr[7:0] + 8'(k);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    inv  = 1'b0;
    resp = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Waits (bounded) for cyc&stb, checks address/tranid, then advances into WAIT.
  task automatic wait_req(input logic [31:0] exp_adr, input logic [3:0] exp_tid, input string tag);
    int n = 0;
    while (!(req.cyc && req.stb) && n < 40) begin
      step();
      n++;
    end
    chk({tag, " req_seen"}, 256'(req.cyc && req.stb), 256'(1));
    chk({tag, " adr"}, 256'(req.adr), 256'(exp_adr));
    chk({tag, " tranid"}, 256'(req.tid.tranid), 256'(exp_tid));
    last_adr = req.adr;
    step();
  endtask

  task automatic respond(input bit is_rty, input logic [3:0] tid);
    resp.ack         = !is_rty;
    resp.rty         = is_rty;
    resp.tid.core    = 6'd1;
    resp.tid.channel = 3'd1;
    resp.tid.tranid  = tid;
    resp.dat         = line_data(last_adr);
    step();
    resp = '0;
  endtask

  initial begin
    fta_cmd_request128_t exp_req;
    int busy;
    csip = 32'h0;
    last_adr = 32'h0;

    // Reset state
    do_reset();
    rst = 1'b1;
    #1;
    exp_req = '0;
    exp_req.tid.core = 6'd1;
    exp_req.tid.channel = 3'd1;
    chk("reset ihit", 256'(ihit), 256'(0));
    chk("reset ibundle", 256'(ibundle), 256'(NOPS));
    chk("reset ftam_req", 256'(req), 256'(exp_req));
    rst = 1'b0;

    // Cold aligned
    do_reset();
    csip = 32'h0000_1000;
    #1;
    chk("cold miss ibundle", 256'(ibundle), 256'(NOPS));
    wait_req(32'h0000_1000, 4'd1, "cold");
    chk("cold wait cyc", 256'({req.cyc, req.stb}), 256'(2'b10));
    respond(1'b0, 4'd1);
    chk("cold ihit", 256'(ihit), 256'(1));
    chk("cold byte0", 256'(ibundle[7:0]), 256'(8'h00));
    chk("cold byte15", 256'(ibundle[127:120]), 256'(8'h0F));

    // Unaligned span
    do_reset();
    csip = 32'h0000_1008;
    wait_req(32'h0000_1000, 4'd1, "span A");
    respond(1'b0, 4'd1);
    chk("span ihit after A", 256'(ihit), 256'(0));
    chk("span nop after A", 256'(ibundle), 256'(NOPS));
    wait_req(32'h0000_1010, 4'd2, "span B");
    respond(1'b0, 4'd2);
    chk("span ihit", 256'(ihit), 256'(1));
    chk("span ibundle", 256'(ibundle), 256'(128'h17161514131211100F0E0D0C0B0A0908));

    // Address wrap
    do_reset();
    csip = 32'hFFFF_FFF0;
    wait_req(32'hFFFF_FFF0, 4'd1, "wrap A");
    respond(1'b0, 4'd1);
    chk("wrap ihit A", 256'(ihit), 256'(1));
    chk("wrap ibundle A", 256'(ibundle), 256'(128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0));
    csip = 32'hFFFF_FFF8;
    wait_req(32'h0000_0000, 4'd2, "wrap B");
    respond(1'b0, 4'd2);
    chk("wrap ihit", 256'(ihit), 256'(1));
    chk("wrap ibundle", 256'(ibundle), 256'(128'h0706050403020100FFFEFDFCFBFAF9F8));

    // Foreign tid ignored, then retry, then ack
    do_reset();
    csip = 32'h0000_3004;
    wait_req(32'h0000_3000, 4'd1, "rty first");
    respond(1'b0, 4'd5);
    chk("foreign tid ignored cyc", 256'(req.cyc), 256'(1));
    chk("foreign tid ignored ihit", 256'(ihit), 256'(0));
    respond(1'b1, 4'd1);
    chk("after rty ihit", 256'(ihit), 256'(0));
    wait_req(32'h0000_3000, 4'd1, "rty reissue");
    respond(1'b0, 4'd1);
    chk("rty A ihit (B missing)", 256'(ihit), 256'(0));
    wait_req(32'h0000_3010, 4'd2, "rty B");
    respond(1'b0, 4'd2);
    chk("rty ihit", 256'(ihit), 256'(1));
    chk("rty ibundle", 256'(ibundle), 256'(128'h13121110_0F0E0D0C0B0A09080706_0504));

    // Invalidate mid-fetch
    do_reset();
    csip = 32'h0000_4000;
    wait_req(32'h0000_4000, 4'd1, "inv first");
    inv = 1'b1;
    step();
    inv = 1'b0;
    respond(1'b0, 4'd1);
    chk("inv dropped ihit", 256'(ihit), 256'(0));
    chk("inv dropped ibundle", 256'(ibundle), 256'(NOPS));
    wait_req(32'h0000_4000, 4'd2, "inv refetch");
    respond(1'b0, 4'd2);
    chk("inv refetch ihit", 256'(ihit), 256'(1));
    inv = 1'b1;
    step();
    inv = 1'b0;
    chk("inv idle clears", 256'(ihit), 256'(0));

    // Reset mid-transaction
    do_reset();
    csip = 32'h0000_5000;
    wait_req(32'h0000_5000, 4'd1, "midrst");
    rst = 1'b1;
    #1;
    chk("midrst cyc low", 256'(req.cyc), 256'(0));
    step();
    step();
    rst = 1'b0;
    wait_req(32'h0000_5000, 4'd1, "midrst restart");
    respond(1'b0, 4'd1);
    chk("midrst ihit", 256'(ihit), 256'(1));

    // Prefetch behaviour
    do_reset();
    csip = 32'h0000_2000;
    wait_req(32'h0000_2000, 4'd1, "pf demand");
    respond(1'b0, 4'd1);
    chk("pf demand ihit", 256'(ihit), 256'(1));
`ifdef RF80386_IBUF_PREFETCH_EN
    wait_req(32'h0000_2010, 4'd2, "pf next");
    respond(1'b0, 4'd2);
    csip = 32'h0000_2010;
    #1;
    chk("pf hit ihit", 256'(ihit), 256'(1));
    chk("pf hit ibundle", 256'(ibundle), 256'(line_data(32'h0000_2010)));
`else
    busy = 0;
    repeat (6) begin
      step();
      if (req.cyc) busy++;
    end
    chk("no prefetch bus", 256'(busy), 256'(0));
    csip = 32'h0000_2010;
    #1;
    chk("no prefetch ihit", 256'(ihit), 256'(0));
`endif

`ifndef RF80386_IBUF_PREFETCH_EN
    // Tranid wrap 15 -> 1 and round-robin eviction
    do_reset();
    for (int i = 0; i < 16; i++) begin
      csip = 32'h0000_6000 + 32'(i * 16);
      wait_req(csip, 4'((i % 15) + 1), $sformatf("tid seq %0d", i));
      respond(1'b0, 4'((i % 15) + 1));
    end
    csip = 32'h0000_60C0;
    #1;
    chk("rr resident ihit", 256'(ihit), 256'(1));
    chk("rr resident ibundle", 256'(ibundle), 256'(line_data(32'h0000_60C0)));
    csip = 32'h0000_60B0;
    #1;
    chk("rr evicted ihit", 256'(ihit), 256'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
